// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with 2-bit counters and a saturating mispredict count
module branch_target_buffer #(
    parameter int ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] cpc,
    output logic        phit,
    output logic [31:0] baddr,
    output logic [31:0] pc4,
    input  logic        upd_en,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_phit,
    input  logic [31:0] upd_baddr,
    output logic        mispred,
    output logic [15:0] mispred_cnt
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [31:0]        target [ENTRIES];
    logic [1:0]         ctr    [ENTRIES];
    logic [IDX_W-1:0]   idx, uidx;
    logic               hit, uhit, mis;
    logic               unused;
    assign unused = ^{cpc[1:0], upd_pc[1:0]};
    always_comb begin
        idx   = cpc[IDX_W+1:2];
        uidx  = upd_pc[IDX_W+1:2];
        hit   = valid[idx] && tag[idx] == cpc[31:IDX_W+2];
        uhit  = valid[uidx] && tag[uidx] == upd_pc[31:IDX_W+2];
        phit  = hit && ctr[idx][1];
        baddr = hit ? target[idx] : 32'd0;
        pc4   = cpc + 32'd4;
        mis   = upd_en && (upd_phit != upd_taken || (upd_taken && upd_phit && upd_baddr != upd_target));
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid       <= '0;
            mispred     <= 1'b0;
            mispred_cnt <= 16'd0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= 32'd0;
                ctr[i]    <= 2'b01;
            end
        end else begin
            mispred <= mis;
            if (mis && mispred_cnt != 16'hFFFF)
                mispred_cnt <= mispred_cnt + 16'd1;
            if (upd_en && uhit) begin
                ctr[uidx] <= upd_taken ? (ctr[uidx] == 2'b11 ? 2'b11 : ctr[uidx] + 2'd1)
                                       : (ctr[uidx] == 2'b00 ? 2'b00 : ctr[uidx] - 2'd1);
                if (upd_taken)
                    target[uidx] <= upd_target;
            end else if (upd_en && upd_taken) begin
                // taken miss allocates or evicts the aliasing line
                valid[uidx]  <= 1'b1;
                tag[uidx]    <= upd_pc[31:IDX_W+2];
                target[uidx] <= upd_target;
                ctr[uidx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer: directed plan plus random traffic checked against a table model of the BTB
module tb_branch_target_buffer;
    localparam int N = 16;
    localparam int IDXW = 4;
    logic        CLK = 1'b0, RST = 1'b1;
    logic [31:0] cpc = '0, upd_pc = '0, upd_target = '0, upd_baddr = '0;
    logic        upd_en = 1'b0, upd_taken = 1'b0, upd_phit = 1'b0;
    logic        phit, mispred;
    logic [31:0] baddr, pc4;
    logic [15:0] mispred_cnt;
    int tests = 0, fails = 0;
    bit chk_en = 1'b0;
    bit          m_valid  [N];
    logic [31:0] m_tag    [N];
    logic [31:0] m_target [N];
    int          m_ctr    [N];
    bit          m_mispred;
    int          m_cnt;

    branch_target_buffer #(.ENTRIES(N)) dut (
        .CLK(CLK), .RST(RST), .cpc(cpc), .phit(phit), .baddr(baddr), .pc4(pc4),
        .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_phit(upd_phit), .upd_baddr(upd_baddr), .mispred(mispred), .mispred_cnt(mispred_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic int midx(logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction
    function automatic logic [31:0] mtag(logic [31:0] pc);
        return pc / (4 * N);
    endfunction
    function automatic bit mhit(logic [31:0] pc);
        return m_valid[midx(pc)] && m_tag[midx(pc)] == mtag(pc);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model advances on each rising edge using the inputs held during that cycle
    task automatic model_clock();
        int  i;
        bit  mis;
        if (RST) begin
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 0; m_tag[k] = 0; m_target[k] = 0; m_ctr[k] = 1;
            end
            m_mispred = 0;
            m_cnt = 0;
        end else begin
            mis = upd_en && (upd_phit != upd_taken || (upd_taken && upd_baddr != upd_target));
            m_mispred = mis;
            if (mis && m_cnt < 65535) m_cnt++;
            i = midx(upd_pc);
            if (upd_en && mhit(upd_pc)) begin
                if (upd_taken) begin
                    m_ctr[i] = m_ctr[i] < 3 ? m_ctr[i] + 1 : 3;
                    m_target[i] = upd_target;
                end else
                    m_ctr[i] = m_ctr[i] > 0 ? m_ctr[i] - 1 : 0;
            end else if (upd_en && upd_taken) begin
                m_valid[i] = 1; m_tag[i] = mtag(upd_pc); m_target[i] = upd_target; m_ctr[i] = 2;
            end
        end
    endtask

    task automatic step(bit rst, logic [31:0] pc, bit en, logic [31:0] upc, bit tk,
                        logic [31:0] tgt, bit ph, logic [31:0] ba);
        @(posedge CLK);
        model_clock();
        #1;
        RST = rst; cpc = pc; upd_en = en; upd_pc = upc; upd_taken = tk;
        upd_target = tgt; upd_phit = ph; upd_baddr = ba;
        @(negedge CLK);
    endtask

    task automatic look(logic [31:0] pc);
        step(0, pc, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("cmp_phit", phit, mhit(cpc) && m_ctr[midx(cpc)] >= 2);
            chk("cmp_baddr", baddr, mhit(cpc) ? m_target[midx(cpc)] : 32'd0);
            chk("cmp_pc4", pc4, cpc + 32'd4);
            chk("cmp_mispred", mispred, m_mispred);
            chk("cmp_cnt", mispred_cnt, m_cnt);
        end
    end

    initial begin
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        step(1, 0, 0, 0, 0, 0, 0, 0);
        look(32'h40);
        chk("rst_phit", phit, 0);
        chk("rst_baddr", baddr, 0);
        chk("rst_pc4", pc4, 32'h44);
        chk("rst_cnt", mispred_cnt, 0);
        // taken miss allocates with weak-taken counter
        step(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 0);
        chk("train_pre_phit", phit, 0);
        look(32'h40);
        chk("train_phit", phit, 1);
        chk("train_baddr", baddr, 32'h100);
        chk("train_ctr", m_ctr[0], 2);
        chk("train_mispred", mispred, 1);
        chk("train_cnt", mispred_cnt, 1);
        step(0, 32'h40, 1, 32'h40, 0, 0, 1, 32'h100);
        look(32'h40);
        chk("hyst_nt1_phit", phit, 0);
        chk("hyst_nt1_ctr", m_ctr[0], 1);
        step(0, 32'h40, 1, 32'h40, 0, 0, 0, 32'h100);
        look(32'h40);
        chk("hyst_nt2_ctr", m_ctr[0], 0);
        chk("hyst_nt2_mispred", mispred, 0);
        step(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h100);
        look(32'h40);
        chk("hyst_t1_phit", phit, 0);
        chk("hyst_t1_ctr", m_ctr[0], 1);
        step(0, 32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h100);
        look(32'h40);
        chk("hyst_t2_phit", phit, 1);
        chk("hyst_t2_ctr", m_ctr[0], 2);
        chk("hyst_cnt", mispred_cnt, 4);
        step(0, 32'h40, 1, 32'h40 + 4 * N, 1, 32'h200, 0, 0);
        chk("alias_pre_baddr", baddr, 32'h100);
        look(32'h40);
        chk("alias_old_baddr", baddr, 0);
        chk("alias_old_phit", phit, 0);
        look(32'h40 + 4 * N);
        chk("alias_new_baddr", baddr, 32'h200);
        step(0, 32'h80, 1, 32'h80, 1, 32'h300, 1, 32'h200);
        chk("same_old_baddr", baddr, 32'h200);
        look(32'h80);
        chk("same_new_baddr", baddr, 32'h300);
        chk("same_new_ctr", m_ctr[0], 3);
        look(32'hFFFF_FFFC);
        chk("wrap_pc4", pc4, 0);
        chk("wrap_baddr", baddr, 0);
        for (int k = 0; k < 65540; k++)
            step(0, 32'h3C, 1, 32'h3C, 0, 0, 1, 0);
        look(32'h3C);
        chk("sat_cnt", mispred_cnt, 16'hFFFF);
        chk("sat_mispred", mispred, 1);
        chk("sat_baddr", baddr, 0);
        step(1, 32'h44, 1, 32'h44, 1, 32'h500, 0, 0);
        look(32'h80);
        chk("rstpri_phit", phit, 0);
        chk("rstpri_baddr", baddr, 0);
        chk("rstpri_mispred", mispred, 0);
        chk("rstpri_cnt", mispred_cnt, 0);
        look(32'h44);
        chk("rstpri_drop", baddr, 0);
        for (int k = 0; k < N; k++) begin
            look(32'h80 + 4 * k);
            chk("rstpri_invalid", {31'd0, phit} | baddr, 0);
        end
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] pc, c, tgt, ba;
            bit tk, ph, rst;
            pc  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2);
            c   = $urandom_range(0, 1) ? (($urandom_range(0, 3) << 6) | ($urandom_range(0, N - 1) << 2)) : $urandom;
            tgt = $urandom_range(0, 3) << 8;
            tk  = $urandom_range(0, 1);
            if ($urandom_range(0, 3) != 0) begin
                ph = mhit(pc) && m_ctr[midx(pc)] >= 2;
                ba = mhit(pc) ? m_target[midx(pc)] : 32'd0;
            end else begin
                ph = $urandom_range(0, 1);
                ba = $urandom_range(0, 3) << 8;
            end
            rst = $urandom_range(0, 199) == 0;
            step(rst, c, $urandom_range(0, 2) != 0, pc, tk, tgt, ph, ba);
        end
        look(0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-side producer of branch predictions for the datapath's next-PC selection logic. Looks up the current fetch PC in a direct-mapped branch target buffer and drives `phit`, `baddr` and `pc4` to the next-PC mux. It is trained by resolved branch outcomes returned from the execute/memory stage using 2-bit saturating counters. It also keeps a saturating mispredict count for performance debug.

## Interface
- `ENTRIES`, 16, number of BTB lines; power of two, at least 2. `IDX_W = $clog2(ENTRIES)`.
- `CLK`  in  1  system clock, all state updates on rising edge.
- `RST`  in  1  reset, synchronous, active-high.
- `cpc`  in  32 (word_t)  current fetch PC.
- `phit`  out  1  predict taken: hit and counter predicts taken.
- `baddr`  out  32  predicted target; 0 when no tag hit.
- `pc4`  out  32  `cpc + 4`, modulo 2^32.
- `upd_en`  in  1  resolved conditional branch or jump presented this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  actual outcome.
- `upd_target`  in  32  actual target; valid when `upd_taken`.
- `upd_phit`  in  1  `phit` the branch carried down the pipe.
- `upd_baddr`  in  32  `baddr` the branch carried down the pipe.
- `mispred`  out  1  registered pulse, one cycle after a mispredicted update.
- `mispred_cnt`  out  16  saturating count of mispredicted updates.

## Operation
- Index is `pc[IDX_W+1:2]` and tag is `pc[31:IDX_W+2]`. Each line holds `valid`, `tag`, `target[31:0]` and `ctr[1:0]`.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. The line predicts taken when `ctr[1]` is 1.
- Lookup is combinational:
  - `hit = valid[idx] && tag[idx] == cpc_tag`.
  - `phit = hit && ctr[1]`.
  - `baddr = hit ? target : 0`.
  - `pc4 = cpc + 4`, with carry dropped.
- Update on `upd_en` at the rising edge, for the line at `upd_pc`'s index:
  - Tag hit, taken: `ctr` increments, saturating at 11; `target <= upd_target`.
  - Tag hit, not taken: `ctr` decrements, saturating at 00; `target` is unchanged.
  - Tag miss, taken: the line is allocated or replaced with `valid=1`, new tag, `target=upd_target`, `ctr=10`.
  - Tag miss, not taken: no change.
- Mispredict is `upd_en && (upd_phit != upd_taken || (upd_taken && upd_phit && upd_baddr != upd_target))`.
  - On mispredict, `mispred` is 1 in the next cycle and `mispred_cnt` increments, holding at 16'hFFFF.
  - `mispred` is 0 in every other cycle.
- Reset:
  - Clears all `valid` bits, `ctr` to 01, `target` and `tag` to 0.
  - `mispred` is 0 and `mispred_cnt` is 0.
  - With all lines invalid, `phit` and `baddr` read 0 immediately after reset.
- `RST` asserted in the same cycle as `upd_en`: reset wins and the update is dropped.

## Timing
- Lookup latency is 0 cycles: `phit`, `baddr` and `pc4` follow `cpc` combinationally in the same cycle.
- Update latency is 1 cycle: the update becomes visible to lookups from the cycle after the `upd_en` edge.
- Simultaneous lookup and update of the same index: the lookup returns the pre-update contents. There is no write-to-read bypass.
- `upd_en` may be asserted on consecutive cycles. Back-to-back updates to the same line compound, for example 01→10→11.
- Aliasing: different PCs with the same index and a different tag replace each other. This only happens on a taken update.
- Wrap-around: `cpc = 32'hFFFF_FFFC` gives `pc4 = 0`.

## Test plan
- Reset, then `cpc=0x40` gives `phit=0`, `baddr=0`, `pc4=0x44`; `mispred_cnt=0`.
- Train, taken miss: `upd_pc=0x40`, `upd_taken=1`, `upd_target=0x100`, `upd_phit=0`.
  - Next cycle `cpc=0x40` gives `phit=1`, `baddr=0x100`, ctr=10.
  - `mispred=1`; `mispred_cnt=1`.
- Hysteresis from ctr=10:
  - Two not-taken updates at 0x40 take ctr 10→01→00; `phit=0` after the first.
  - Then one taken update gives ctr=01, `phit` still 0.
  - Then a second taken update gives ctr=10, `phit=1`.
- Alias replacement: with 0x40 trained, a taken update for `0x40 + 4*ENTRIES` with target 0x200 replaces the line.
  - Lookup of 0x40 misses (`baddr=0`).
  - Lookup of the alias gives `baddr=0x200`.
- Same-cycle lookup and update of 0x80: lookup shows the old contents that cycle and the new contents the following cycle.
  - Also drive `cpc=0xFFFF_FFFC` and check `pc4=0`.
- Counter saturation and reset priority:
  - Force 65540 mispredicted updates; `mispred_cnt` holds at 0xFFFF.
  - Assert `RST` together with `upd_en`: every output reads its reset value and no line is valid.
